// File: rtl/fifo_prefetch_ctrl.sv
// fifo_prefetch_ctrl: credit-based burst prefetcher that refills the pixel FIFO from frame memory
module fifo_prefetch_ctrl #(
    parameter int          ADDR_W      = 24,
    parameter int          FIFO_DEPTH  = 256,
    parameter int          BURST       = 16,
    parameter int          FRAME_WORDS = 76800,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             start_frame,
    input  logic                             fifo_pop,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [$clog2(BURST):0]           mem_len,
    input  logic                             mem_ack,
    input  logic                             mem_rvalid,
    output logic                             fifo_write,
    output logic                             fifo_flush,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             frame_done,
    output logic                             underrun
);
    localparam int LW  = $clog2(FIFO_DEPTH+1);
    localparam int NW  = $clog2(BURST)+1;
    localparam int RW0 = $clog2(FRAME_WORDS+1);
    localparam int RW  = RW0 > NW ? RW0 : NW;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NW-1:0]     len_q, len_d, next_len;
    logic [RW-1:0]     rem_q, rem_d, next_len_w;
    logic [LW-1:0]     out_q, out_d, level_q, level_d, credits;
    logic              under_q, under_d;
    logic              hs, rv, pop_ok, flush;

    always_comb begin
        hs         = state_q == REQ && mem_ack;
        // a word with nothing in flight is a protocol error and is ignored
        rv         = mem_rvalid && out_q != '0;
        pop_ok     = fifo_pop && level_q != '0;
        flush      = state_q == DRAIN && out_q == '0 && !start_frame;
        fifo_write = rv && state_q != DRAIN && !start_frame;
        fifo_flush = flush;
        credits    = LW'(FIFO_DEPTH) - level_q - out_q;
        next_len_w = rem_q < RW'(BURST) ? rem_q : RW'(BURST);
        next_len   = NW'(next_len_w);
        frame_done = fifo_write && rem_q == '0 && out_q == LW'(1);
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        out_d      = out_q + (hs ? LW'(len_q) : '0) - LW'(rv);
        level_d    = level_q + LW'(fifo_write) - LW'(pop_ok);
        under_d    = (under_q || (fifo_pop && level_q == '0)) && !start_frame;
        if (hs) begin
            addr_d  = addr_q + ADDR_W'(len_q);
            rem_d   = rem_q - RW'(len_q);
            state_d = IDLE;
        end
        // only issue when the whole burst is guaranteed to fit
        if (state_q == IDLE && enable && rem_q != '0 && credits >= LW'(next_len)) begin
            state_d = REQ;
            len_d   = next_len;
        end
        if (flush) begin
            state_d = IDLE;
            level_d = '0;
            rem_d   = RW'(FRAME_WORDS);
            addr_d  = ADDR_W'(BASE_ADDR);
            under_d = 1'b0;
        end
        if (start_frame) state_d = DRAIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            len_q   <= '0;
            rem_q   <= RW'(FRAME_WORDS);
            out_q   <= '0;
            level_q <= '0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            level_q <= level_d;
            under_q <= under_d;
        end
    end

    assign mem_req  = state_q == REQ;
    assign mem_addr = addr_q;
    assign mem_len  = len_q;
    assign level    = level_q;
    assign underrun = under_q;
endmodule

// File: tb/tb_fifo_prefetch_ctrl.sv
// tb_fifo_prefetch_ctrl: directed bench with a memory responder and a request scoreboard
module tb_fifo_prefetch_ctrl;
    localparam int FW = 300;

    logic        clk = 0, reset = 1, enable = 0, start_frame = 0;
    logic        man_pop = 0, auto_pop = 0, pop_mode = 0, fifo_pop;
    logic        mem_req, mem_ack = 0, mem_rvalid = 0;
    logic        fifo_write, fifo_flush, frame_done, underrun;
    logic [23:0] mem_addr;
    logic [4:0]  mem_len;
    logic [8:0]  level;
    logic        ack_en = 1, gate = 1;

    int n_cmp = 0, n_err = 0;
    int edge_i = 0, last_t = 0, req_cnt = 0;
    int wr_cnt = 0, rv_cnt = 0, fd_cnt = 0, fd_wr = 0, fl_cnt = 0, fl_rv = 0;
    int dq[$];
    int obs_q[$];
    int exp_q[$];

    assign fifo_pop = man_pop | auto_pop;

    fifo_prefetch_ctrl #(
        .ADDR_W(24), .FIFO_DEPTH(256), .BURST(16), .FRAME_WORDS(FW), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .start_frame(start_frame),
        .fifo_pop(fifo_pop), .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .fifo_write(fifo_write),
        .fifo_flush(fifo_flush), .level(level), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // memory: ack one cycle after req, words from 3 cycles after the handshake, held while gate=0
    always @(posedge clk) begin
        #1;
        edge_i++;
        auto_pop = pop_mode && level != 0;
        mem_rvalid = gate && dq.size() > 0 && dq[0] <= edge_i + 1;
        if (mem_rvalid) void'(dq.pop_front());
        if (mem_req && !mem_ack && ack_en) begin
            mem_ack = 1;
            req_cnt++;
            obs_q.push_back(int'(mem_addr) * 32 + int'(mem_len));
            for (int i = 0; i < int'(mem_len); i++) begin
                last_t = (last_t + 1 > edge_i + 4) ? last_t + 1 : edge_i + 4;
                dq.push_back(last_t);
            end
        end else mem_ack = 0;
    end

    always @(negedge clk) begin
        if (fifo_write) wr_cnt++;
        if (mem_rvalid) rv_cnt++;
        if (frame_done) begin fd_cnt++; fd_wr = wr_cnt; end
        if (fifo_flush) begin fl_cnt++; fl_rv = rv_cnt; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        int o, e;
        @(posedge clk);
        #2;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) chk("req_unexpected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("req_addr", o / 32, e / 32);
                chk("req_len", o % 32, e % 32);
            end
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_mem_req"}, mem_req, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_len"}, mem_len, 0);
        chk({pfx, "_fifo_write"}, fifo_write, 0);
        chk({pfx, "_fifo_flush"}, fifo_flush, 0);
        chk({pfx, "_level"}, level, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_underrun"}, underrun, 0);
    endtask

    initial begin
        int base, wb, rvb, fl0;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 0;
        tick();

        // fill from empty: 16 bursts, then credits run out
        for (int i = 0; i < 16; i++) exp_q.push_back(i * 16 * 32 + 16);
        enable = 1;
        for (int i = 0; i < 400 && level != 256; i++) tick();
        chk("fill_level", level, 256);
        repeat (20) tick();
        chk("fill_hold", level, 256);
        chk("fill_reqs", req_cnt, 16);
        chk("fill_sb_left", exp_q.size(), 0);
        chk("fill_no_req", mem_req, 0);

        // 15 pops leave too few credits; the 16th frees a burst
        man_pop = 1;
        repeat (15) tick();
        man_pop = 0;
        repeat (8) tick();
        chk("pop15_level", level, 241);
        chk("pop15_reqs", req_cnt, 16);
        exp_q.push_back(256 * 32 + 16);
        man_pop = 1;
        tick();
        man_pop = 0;
        chk("pop16_level", level, 240);
        chk("pop16_req_lat", mem_req, 0);
        tick();
        chk("pop16_req", mem_req, 1);
        chk("pop16_addr", mem_addr, 256);
        chk("pop16_len", mem_len, 16);

        // rest of the frame with continuous pops: short last burst, one frame_done
        exp_q.push_back(272 * 32 + 16);
        exp_q.push_back(288 * 32 + 12);
        pop_mode = 1;
        for (int i = 0; i < 1000 && !(wr_cnt == FW && level == 0); i++) tick();
        chk("frame_writes", wr_cnt, FW);
        chk("frame_done_cnt", fd_cnt, 1);
        chk("frame_done_word", fd_wr, FW);
        repeat (20) tick();
        chk("frame_end_reqs", req_cnt, 19);
        chk("frame_sb_left", exp_q.size(), 0);
        chk("frame_underrun", underrun, 0);
        pop_mode = 0;

        // restart, then abort with 32 words in flight
        start_frame = 1;
        tick();
        start_frame = 0;
        for (int i = 0; i < 10 && fl_cnt == 0; i++) tick();
        chk("restart_flush", fl_cnt, 1);
        gate = 0;
        exp_q.push_back(0 * 32 + 16);
        exp_q.push_back(16 * 32 + 16);
        base = req_cnt;
        enable = 1;
        for (int i = 0; i < 20 && req_cnt < base + 2; i++) tick();
        enable = 0;
        repeat (4) tick();
        chk("inflight_reqs", req_cnt, base + 2);
        rvb = rv_cnt;
        wb = wr_cnt;
        fl0 = fl_cnt;
        start_frame = 1;
        tick();
        start_frame = 0;
        chk("drain_req_low", mem_req, 0);
        repeat (3) tick();
        gate = 1;
        for (int i = 0; i < 100 && fl_cnt == fl0; i++) tick();
        chk("drain_flush", fl_cnt, fl0 + 1);
        chk("drain_words", fl_rv - rvb, 32);
        chk("drain_no_write", wr_cnt, wb);
        repeat (5) tick();
        chk("drain_flush_once", fl_cnt, fl0 + 1);
        for (int i = 0; i < 16; i++) exp_q.push_back(i * 16 * 32 + 16);
        enable = 1;
        tick();
        chk("drain_next_req", mem_req, 1);
        chk("drain_next_addr", mem_addr, 0);
        chk("drain_next_level", level, 0);

        // simultaneous pop and write at level 100
        for (int i = 0; i < 400 && level != 256; i++) tick();
        chk("refill_level", level, 256);
        enable = 0;
        man_pop = 1;
        repeat (156) tick();
        man_pop = 0;
        chk("lvl100", level, 100);
        gate = 0;
        exp_q.push_back(256 * 32 + 16);
        exp_q.push_back(272 * 32 + 16);
        exp_q.push_back(288 * 32 + 12);
        base = req_cnt;
        enable = 1;
        for (int i = 0; i < 40 && req_cnt < base + 3; i++) tick();
        enable = 0;
        repeat (6) tick();
        chk("tail_reqs", req_cnt, base + 3);
        chk("tail_sb_left", exp_q.size(), 0);
        gate = 1;
        tick();
        man_pop = 1;
        gate = 0;
        chk("both_write", fifo_write, 1);
        chk("both_pre_level", level, 100);
        tick();
        man_pop = 0;
        chk("both_level", level, 100);

        // underrun set by a pop at level 0, cleared by start_frame
        man_pop = 1;
        repeat (100) tick();
        man_pop = 0;
        chk("empty_level", level, 0);
        chk("empty_underrun", underrun, 0);
        man_pop = 1;
        tick();
        man_pop = 0;
        chk("underrun_set", underrun, 1);
        chk("underrun_level", level, 0);
        repeat (5) tick();
        chk("underrun_hold", underrun, 1);
        start_frame = 1;
        tick();
        start_frame = 0;
        chk("underrun_clr", underrun, 0);
        wb = wr_cnt;
        fl0 = fl_cnt;
        gate = 1;
        for (int i = 0; i < 100 && fl_cnt == fl0; i++) tick();
        chk("drain2_flush", fl_cnt, fl0 + 1);
        chk("drain2_no_write", wr_cnt, wb);

        // request held without ack and despite enable dropping, then async reset
        ack_en = 0;
        enable = 1;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        chk("hold_req", mem_req, 1);
        enable = 0;
        repeat (3) tick();
        chk("hold_req_stable", mem_req, 1);
        chk("hold_addr", mem_addr, 0);
        chk("hold_len", mem_len, 16);
        #1 reset = 1;
        #1;
        chk_reset_vals("async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
